// File: rtl/dmem_arbiter.sv
// Shares the data-memory/IO port between the pipeline MEM stage (priority) and a
// debug/loader port; a starvation counter eventually forces a one-cycle pipeline stall.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  // pipeline MEM stage
  input  logic [31:0]      pipe_addr,
  input  logic [31:0]      pipe_datain,
  input  logic             pipe_wmem,
  input  logic             pipe_rmem,
  output logic             pipe_stall,
  // debug / loader port
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  // RAM/IO block
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_datain,
  output logic             mem_we,
  input  logic [31:0]      mem_dataout,
  // observability
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] starve_count
);

  // Handshake: dbg_req is a level held by the requester; dbg_ack is a one-cycle
  // pulse two cycles after grant. After an ack, dbg_req must be seen low for at
  // least one cycle before another grant. The pipeline never waits except in the
  // single DBG_ACC cycle, where pipe_stall tells it to retry its access.

  if ((1 << CNT_W) <= STARVE_LIMIT) begin : g_cnt_w_check
    $error("dmem_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DBG_ACC  = 2'd1,
    DBG_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             armed;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;

  logic pipe_busy;
  logic starved;
  logic dbg_pending;
  logic grant;

  assign pipe_busy   = pipe_wmem | pipe_rmem;
  assign starved     = (starve_cnt == LIMIT);
  assign dbg_pending = dbg_req & armed;
  assign grant       = (state == IDLE) & dbg_pending & (~pipe_busy | starved);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      armed      <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dbg_ack <= 1'b0;
          if (grant) begin
            lat_we     <= dbg_we;
            lat_addr   <= dbg_addr;
            lat_wdata  <= dbg_wdata;
            starve_cnt <= '0;
            state      <= DBG_ACC;
          end else if (dbg_pending && pipe_busy && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        DBG_ACC: begin
          if (!lat_we) dbg_rdata <= mem_dataout;
          dbg_ack <= 1'b1;
          state   <= DBG_RESP;
        end
        DBG_RESP: begin
          dbg_ack <= 1'b0;
          armed   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          dbg_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
      // A low request re-arms, even in the ack cycle itself.
      if (!dbg_req) armed <= 1'b1;
    end
  end

  always_comb begin
    pipe_stall = 1'b0;
    mem_addr   = pipe_addr;
    mem_datain = pipe_datain;
    mem_we     = pipe_wmem;
    if (state == DBG_ACC) begin
      pipe_stall = 1'b1;
      mem_addr   = lat_addr;
      mem_datain = lat_wdata;
      mem_we     = lat_we;
    end
  end

  assign fsm_state    = state;
  assign starve_count = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a timeline-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_dmem_arbiter;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0]      pipe_addr = '0, pipe_datain = '0;
  logic             pipe_wmem = 1'b0, pipe_rmem = 1'b0;
  logic             pipe_stall;
  logic             dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0]      dbg_addr = '0, dbg_wdata = '0;
  logic             dbg_ack;
  logic [31:0]      dbg_rdata;
  logic [31:0]      mem_addr, mem_datain, mem_dataout;
  logic             mem_we;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] starve_count;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .pipe_addr(pipe_addr), .pipe_datain(pipe_datain),
    .pipe_wmem(pipe_wmem), .pipe_rmem(pipe_rmem), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
    .mem_dataout(mem_dataout),
    .fsm_state(fsm_state), .starve_count(starve_count)
  );

  // Environment RAM/IO block: combinational read, write on the rising edge.
  logic [31:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  assign mem_dataout = ram[mem_addr[7:0]];
  always @(posedge clock) if (mem_we) ram[mem_addr[7:0]] <= mem_datain;

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks the cycle index at which the debug access occupies the bus; the
  // acknowledge cycle is the one right after it. exp_mem mirrors what the bus
  // should have written so far.
  int          m_cyc   = 0;
  int          m_acc   = -10;
  int          m_wait  = 0;
  bit          m_armed = 1'b1;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0, m_wdata = '0, m_rdata = '0;
  logic [31:0] exp_mem [256];
  initial for (int i = 0; i < 256; i++) exp_mem[i] = '0;

  always @(posedge clock or posedge reset) begin
    bit in_acc, in_resp;
    if (reset) begin
      m_acc = -10; m_wait = 0; m_armed = 1'b1;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      in_acc  = (m_cyc == m_acc);
      in_resp = (m_cyc == m_acc + 1);
      if (in_acc) begin
        if (m_we) exp_mem[m_addr[7:0]] = m_wdata;
        else      m_rdata = exp_mem[m_addr[7:0]];
      end else if (pipe_wmem) begin
        exp_mem[pipe_addr[7:0]] = pipe_datain;
      end
      if (!in_acc && !in_resp && dbg_req && m_armed) begin
        if (!(pipe_wmem || pipe_rmem) || m_wait == STARVE_LIMIT) begin
          m_acc = m_cyc + 1; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      if (in_resp) m_armed = 1'b0;
      if (!dbg_req) m_armed = 1'b1;
      m_cyc++;
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clock) begin
    bit acc, resp;
    acc  = (m_cyc == m_acc);
    resp = (m_cyc == m_acc + 1);
    chk("cmp_pipe_stall", 32'(pipe_stall), 32'(acc));
    chk("cmp_dbg_ack",    32'(dbg_ack),    32'(resp));
    chk("cmp_mem_addr",   mem_addr,        acc ? m_addr  : pipe_addr);
    chk("cmp_mem_datain", mem_datain,      acc ? m_wdata : pipe_datain);
    chk("cmp_mem_we",     32'(mem_we),     32'(acc ? m_we : pipe_wmem));
    chk("cmp_dbg_rdata",  dbg_rdata,       m_rdata);
    chk("cmp_fsm_state",  32'(fsm_state),  acc ? 32'd1 : (resp ? 32'd2 : 32'd0));
    chk("cmp_starve_cnt", 32'(starve_count), 32'(m_wait));
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic dbg_issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with a pipeline store on the bus: pure pass-through.
    reset = 1'b1; pipe_wmem = 1'b1; pipe_addr = 32'h44; pipe_datain = 32'h0BAD_0044;
    sample();
    chk("rst_stall",  32'(pipe_stall), 32'd0);
    chk("rst_ack",    32'(dbg_ack),    32'd0);
    chk("rst_rdata",  dbg_rdata,       32'h0);
    chk("rst_mem_we", 32'(mem_we),     32'd1);
    chk("rst_addr",   mem_addr,        32'h44);
    next_cycle();
    reset = 1'b0; pipe_wmem = 1'b0; pipe_addr = '0; pipe_datain = '0;
    idle(2);

    // Debug write, idle pipeline; request dropped during the access cycle.
    dbg_issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    next_cycle(); dbg_req = 1'b0;
    sample();
    chk("wr_mem_we",  32'(mem_we),  32'd1);
    chk("wr_addr",    mem_addr,     32'h10);
    chk("wr_data",    mem_datain,   32'hDEAD_BEEF);
    chk("wr_stall",   32'(pipe_stall), 32'd1);
    next_cycle(); sample();
    chk("wr_ack",     32'(dbg_ack), 32'd1);
    chk("wr_stall_off", 32'(pipe_stall), 32'd0);
    next_cycle(); sample();
    chk("wr_ack_pulse", 32'(dbg_ack), 32'd0);
    idle(1);

    // Debug read back, then a write must not disturb dbg_rdata.
    dbg_issue(1'b0, 32'h10, 32'h0);
    next_cycle(); dbg_req = 1'b0;
    next_cycle(); sample();
    chk("rd_ack",   32'(dbg_ack), 32'd1);
    chk("rd_rdata", dbg_rdata,    32'hDEAD_BEEF);
    idle(1);
    dbg_issue(1'b1, 32'h20, 32'h1234_5678);
    next_cycle(); dbg_req = 1'b0;
    next_cycle(); sample();
    chk("wr2_ack",        32'(dbg_ack), 32'd1);
    chk("rd_rdata_held",  dbg_rdata,    32'hDEAD_BEEF);
    idle(2);

    // Starvation: pipeline load held continuously.
    pipe_rmem = 1'b1; pipe_addr = 32'h30;
    dbg_issue(1'b0, 32'h20, 32'h0);                  // cycle 0
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); sample();
      chk("starve_no_stall", 32'(pipe_stall), 32'd0);
    end
    chk("starve_cnt_8", 32'(starve_count), 32'd8);   // cycle 8
    next_cycle(); dbg_req = 1'b0; sample();          // cycle 9
    chk("starve_stall_c9", 32'(pipe_stall), 32'd1);
    chk("starve_addr_c9",  mem_addr,        32'h20);
    next_cycle(); sample();                           // cycle 10
    chk("starve_ack_c10",   32'(dbg_ack),    32'd1);
    chk("starve_stall_c10", 32'(pipe_stall), 32'd0);
    chk("starve_rdata",     dbg_rdata,       32'h1234_5678);
    pipe_rmem = 1'b0; pipe_addr = '0;
    idle(2);

    // Request held across ack: no re-grant until it has been low.
    dbg_issue(1'b1, 32'h11, 32'hA5A5_A5A5);          // cycle 0
    next_cycle(); sample();
    chk("hold_stall_c1", 32'(pipe_stall), 32'd1);
    next_cycle(); sample();
    chk("hold_ack_c2", 32'(dbg_ack), 32'd1);
    for (int c = 3; c <= 6; c++) begin
      next_cycle(); sample();
      chk("hold_no_regrant", 32'(pipe_stall), 32'd0);
    end
    next_cycle(); dbg_req = 1'b0; sample();          // cycle 7
    next_cycle(); dbg_issue(1'b0, 32'h11, 32'h0); sample(); // cycle 8
    chk("hold_stall_c8", 32'(pipe_stall), 32'd0);
    next_cycle(); dbg_req = 1'b0; sample();          // cycle 9
    chk("hold_regrant", 32'(pipe_stall), 32'd1);
    next_cycle(); sample();                           // cycle 10
    chk("hold_ack2",   32'(dbg_ack), 32'd1);
    chk("hold_rdata",  dbg_rdata,    32'hA5A5_A5A5);
    idle(2);

    // IO debug write collides with a pipeline store; the store is retried.
    dbg_issue(1'b1, 32'h80, 32'hCAFE_F00D);
    next_cycle();
    dbg_req = 1'b0; pipe_wmem = 1'b1; pipe_addr = 32'h84; pipe_datain = 32'h1111_2222;
    sample();
    chk("io_addr",  mem_addr,        32'h80);
    chk("io_data",  mem_datain,      32'hCAFE_F00D);
    chk("io_we",    32'(mem_we),     32'd1);
    chk("io_stall", 32'(pipe_stall), 32'd1);
    next_cycle(); sample();
    chk("retry_addr",  mem_addr,        32'h84);
    chk("retry_data",  mem_datain,      32'h1111_2222);
    chk("retry_we",    32'(mem_we),     32'd1);
    chk("retry_stall", 32'(pipe_stall), 32'd0);
    chk("retry_ack",   32'(dbg_ack),    32'd1);
    next_cycle(); pipe_wmem = 1'b0; pipe_addr = '0; pipe_datain = '0;
    idle(1);
    chk("ram_io_write", ram[8'h80], 32'hCAFE_F00D);
    chk("ram_retry",    ram[8'h84], 32'h1111_2222);

    // Reset in the middle of a debug write access.
    dbg_issue(1'b1, 32'h40, 32'h0000_0055);
    next_cycle(); dbg_req = 1'b0; sample();
    chk("abort_pre_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_we",    32'(mem_we),     32'd0);
    chk("abort_stall", 32'(pipe_stall), 32'd0);
    chk("abort_state", 32'(fsm_state),  32'd0);
    chk("abort_rdata", dbg_rdata,       32'h0);
    next_cycle(); next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("abort_no_ack", 32'(dbg_ack), 32'd0);
      next_cycle();
    end
    chk("abort_ram", ram[8'h40], 32'h0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
